// File: rtl/blink_period_meter_if.sv
// Signal bundle between a blink source/consumer and blink_period_meter.
// The master drives enable and the blink input; the slave (the meter) returns the measurements.
interface blink_period_meter_if #(
    parameter int CNT_W = 32
);
    logic             enable;
    logic             sig_in;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] low_cnt;
    logic [CNT_W-1:0] period_cnt;
    logic             meas_valid;
    logic             timeout;

    modport master (
        output enable, sig_in,
        input  high_cnt, low_cnt, period_cnt, meas_valid, timeout
    );

    modport slave (
        input  enable, sig_in,
        output high_cnt, low_cnt, period_cnt, meas_valid, timeout
    );
endinterface

// File: rtl/blink_period_meter.sv
// Measures high time, low time and period (in clk cycles) of an asynchronous blink input.
// A phase longer than TIMEOUT raises a sticky timeout flag and re-arms the measurement.
module blink_period_meter #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 200_000_000
) (
    input  logic clk,
    input  logic rst,
    blink_period_meter_if.slave bus
);
    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_t;

    state_t           state, state_n;
    logic             sig_p0, sig_p1, sig_p2;
    logic             rise, fall;
    logic [CNT_W-1:0] hcnt, hcnt_n, lcnt, lcnt_n;
    logic             latch, to_set, to_clr;
    logic [CNT_W-1:0] high_q, low_q, period_q;
    logic             mv_q, to_q;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    // Stage p0/p1: two-flop synchroniser; p2: one-cycle delay for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_p0 <= 1'b0;
            sig_p1 <= 1'b0;
            sig_p2 <= 1'b0;
        end else begin
            sig_p0 <= bus.sig_in;
            sig_p1 <= sig_p0;
            sig_p2 <= sig_p1;
        end
    end

    assign rise = sig_p1 & ~sig_p2;
    assign fall = ~sig_p1 & sig_p2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            hcnt  <= '0;
            lcnt  <= '0;
        end else begin
            state <= state_n;
            hcnt  <= hcnt_n;
            lcnt  <= lcnt_n;
        end
    end

    // An edge on the cycle a phase reaches TIMEOUT takes priority over the timeout
    always_comb begin
        state_n = state;
        hcnt_n  = hcnt;
        lcnt_n  = lcnt;
        latch   = 1'b0;
        to_set  = 1'b0;
        to_clr  = 1'b0;
        if (!bus.enable) begin
            state_n = IDLE;
            hcnt_n  = '0;
            lcnt_n  = '0;
            to_clr  = 1'b1;
        end else begin
            case (state)
                IDLE: state_n = ARM;
                ARM: begin
                    if (rise) begin
                        state_n = HIGH;
                        hcnt_n  = ONE;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        state_n = LOW;
                        lcnt_n  = ONE;
                    end else if (hcnt == TO_LIM) begin
                        state_n = ARM;
                        hcnt_n  = '0;
                        lcnt_n  = '0;
                        to_set  = 1'b1;
                    end else begin
                        hcnt_n = hcnt + ONE;
                    end
                end
                LOW: begin
                    if (rise) begin
                        state_n = HIGH;
                        hcnt_n  = ONE;
                        latch   = 1'b1;
                    end else if (lcnt == TO_LIM) begin
                        state_n = ARM;
                        hcnt_n  = '0;
                        lcnt_n  = '0;
                        to_set  = 1'b1;
                    end else begin
                        lcnt_n = lcnt + ONE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Output stage: results only change on a completed period
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            high_q   <= '0;
            low_q    <= '0;
            period_q <= '0;
            mv_q     <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            mv_q <= latch;
            if (latch) begin
                high_q   <= hcnt;
                low_q    <= lcnt;
                period_q <= sat_add(hcnt, lcnt);
                to_q     <= 1'b0;
            end else if (to_set) begin
                to_q <= 1'b1;
            end else if (to_clr) begin
                to_q <= 1'b0;
            end
        end
    end

    assign bus.high_cnt   = high_q;
    assign bus.low_cnt    = low_q;
    assign bus.period_cnt = period_q;
    assign bus.meas_valid = mv_q;
    assign bus.timeout    = to_q;
endmodule

// File: tb/tb_blink_period_meter.sv
// Bench for blink_period_meter: two instances (TIMEOUT 50 and 200, 8-bit counters) driven by
// the same directed phase sequence, checked every cycle against a phase-level event model.
module tb_blink_period_meter;
    localparam int CW     = 8;
    localparam int MAXV   = 255;
    localparam int K_MEAS = 0;
    localparam int K_TO   = 1;
    localparam int K_CLR  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    logic sig = 1'b0;

    initial forever #5 clk = ~clk;

    blink_period_meter_if #(.CNT_W(CW)) ifa ();
    blink_period_meter_if #(.CNT_W(CW)) ifb ();

    assign ifa.enable = enable;
    assign ifa.sig_in = sig;
    assign ifb.enable = enable;
    assign ifb.sig_in = sig;

    blink_period_meter #(.CNT_W(CW), .TIMEOUT(50))  dut_a (.clk(clk), .rst(rst), .bus(ifa));
    blink_period_meter #(.CNT_W(CW), .TIMEOUT(200)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    logic [CW-1:0] act_h [2];
    logic [CW-1:0] act_l [2];
    logic [CW-1:0] act_p [2];
    logic          act_mv[2];
    logic          act_to[2];

    assign act_h[0] = ifa.high_cnt;   assign act_h[1] = ifb.high_cnt;
    assign act_l[0] = ifa.low_cnt;    assign act_l[1] = ifb.low_cnt;
    assign act_p[0] = ifa.period_cnt; assign act_p[1] = ifb.period_cnt;
    assign act_mv[0] = ifa.meas_valid; assign act_mv[1] = ifb.meas_valid;
    assign act_to[0] = ifa.timeout;   assign act_to[1] = ifb.timeout;

    typedef struct {
        int inst;
        int cyc;
        int kind;
        int h;
        int l;
    } ev_t;

    ev_t evq[$];
    int  cyc = 0;
    int  exp_h[2], exp_l[2], exp_p[2];
    int  exp_mv[2], exp_to[2];
    int  mstate[2], last_h[2], last_l[2];
    int  mvcnt[2];
    int  n_chk = 0;
    int  n_pass = 0;

    function automatic int tov(input int i);
        return (i == 0) ? 50 : 200;
    endfunction

    task automatic chk(input string nm, input int inst, input int act, input int expv);
        n_chk++;
        if (act == expv) n_pass++;
        else $display("FAIL %s[inst %0d] cycle %0d: got %0d, expected %0d", nm, inst, cyc, act, expv);
    endtask

    // Model: applies scheduled phase-level events on the clock edge they are due
    initial begin : model
        forever begin
            @(posedge clk);
            cyc++;
            for (int i = 0; i < 2; i++) exp_mv[i] = 0;
            if (rst) begin
                for (int i = 0; i < 2; i++) begin
                    exp_h[i] = 0; exp_l[i] = 0; exp_p[i] = 0; exp_to[i] = 0;
                end
            end else begin
                foreach (evq[k]) begin
                    if (evq[k].cyc == cyc) begin
                        case (evq[k].kind)
                            K_MEAS: begin
                                exp_h[evq[k].inst]  = evq[k].h;
                                exp_l[evq[k].inst]  = evq[k].l;
                                exp_p[evq[k].inst]  = (evq[k].h + evq[k].l > MAXV) ? MAXV : evq[k].h + evq[k].l;
                                exp_mv[evq[k].inst] = 1;
                                exp_to[evq[k].inst] = 0;
                            end
                            K_TO:    exp_to[evq[k].inst] = 1;
                            default: exp_to[evq[k].inst] = 0;
                        endcase
                    end
                end
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                chk("meas_valid", i, int'(act_mv[i]), rst ? 0 : exp_mv[i]);
                chk("timeout",    i, int'(act_to[i]), rst ? 0 : exp_to[i]);
                chk("high_cnt",   i, int'(act_h[i]),  rst ? 0 : exp_h[i]);
                chk("low_cnt",    i, int'(act_l[i]),  rst ? 0 : exp_l[i]);
                chk("period_cnt", i, int'(act_p[i]),  rst ? 0 : exp_p[i]);
                if (act_mv[i]) mvcnt[i]++;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input int i, input int c, input int k, input int h, input int l);
        ev_t e;
        e.inst = i; e.cyc = c; e.kind = k; e.h = h; e.l = l;
        evq.push_back(e);
    endtask

    task automatic cancel_from(input int c);
        ev_t keep[$];
        foreach (evq[k]) if (evq[k].cyc < c) keep.push_back(evq[k]);
        evq = keep;
    endtask

    // Start a phase of n cycles at level lvl; an input change reaches the outputs 2 edges later
    task automatic seg_start(input bit lvl, input int n);
        int c;
        c = cyc + 1;
        for (int i = 0; i < 2; i++) begin
            if (lvl) begin
                if (mstate[i] == 2) push(i, c + 2, K_MEAS, last_h[i], last_l[i]);
                mstate[i] = 1;
                last_h[i] = n;
            end else if (mstate[i] == 1) begin
                mstate[i] = 2;
                last_l[i] = n;
            end
            if (mstate[i] != 0 && n > tov(i)) begin
                push(i, c + 2 + tov(i), K_TO, 0, 0);
                mstate[i] = 0;
            end
        end
        sig = lvl;
    endtask

    task automatic seg(input bit lvl, input int n);
        seg_start(lvl, n);
        wait_cyc(n);
    endtask

    task automatic drop_enable(input int n);
        int c;
        c = cyc + 1;
        enable = 1'b0;
        cancel_from(c);
        for (int i = 0; i < 2; i++) begin
            push(i, c, K_CLR, 0, 0);
            mstate[i] = 0;
        end
        wait_cyc(n);
        enable = 1'b1;
    endtask

    task automatic settle();
        #2;
    endtask

    int s0, s1;

    initial begin : stim
        wait_cyc(3);
        settle();
        chk("rst_high", 0, int'(act_h[0]), 0);
        chk("rst_period", 1, int'(act_p[1]), 0);
        chk("rst_timeout", 0, int'(act_to[0]), 0);
        @(negedge clk);
        rst = 1'b0;
        enable = 1'b1;
        wait_cyc(4);

        // 3 high / 5 low square wave
        s0 = mvcnt[0]; s1 = mvcnt[1];
        seg(1, 3);
        repeat (5) begin
            seg(0, 5);
            seg(1, 3);
        end
        settle();
        chk("sq_strobes", 0, mvcnt[0] - s0, 5);
        chk("sq_strobes", 1, mvcnt[1] - s1, 5);
        chk("sq_high", 0, int'(act_h[0]), 3);
        chk("sq_low", 0, int'(act_l[0]), 5);
        chk("sq_period", 0, int'(act_p[0]), 8);

        // Stuck high for 60 cycles: only the TIMEOUT=50 instance times out
        seg(0, 5);
        seg(1, 60);
        settle();
        chk("stuck_timeout", 0, int'(act_to[0]), 1);
        chk("stuck_held_high", 0, int'(act_h[0]), 3);
        chk("stuck_no_timeout", 1, int'(act_to[1]), 0);
        s0 = mvcnt[0];
        seg(0, 4); seg(1, 4); seg(0, 4); seg(1, 4);
        settle();
        chk("recover_strobes", 0, mvcnt[0] - s0, 1);
        chk("recover_period", 0, int'(act_p[0]), 8);
        chk("recover_timeout", 0, int'(act_to[0]), 0);

        // Phases of exactly TIMEOUT cycles: the edge wins
        seg(0, 4); seg(1, 50); seg(0, 50); seg(1, 4);
        settle();
        chk("edge_wins_timeout", 0, int'(act_to[0]), 0);
        chk("edge_wins_high", 0, int'(act_h[0]), 50);
        chk("edge_wins_period", 0, int'(act_p[0]), 100);

        // 150/150 saturates the 8-bit period
        seg(0, 3); seg(1, 150); seg(0, 150);
        seg_start(1, 20);
        wait_cyc(8);
        settle();
        chk("sat_high", 1, int'(act_h[1]), 150);
        chk("sat_low", 1, int'(act_l[1]), 150);
        chk("sat_period", 1, int'(act_p[1]), 255);
        chk("long_timeout", 0, int'(act_to[0]), 1);

        // enable dropped for one cycle mid-HIGH
        s0 = mvcnt[0]; s1 = mvcnt[1];
        drop_enable(1);
        wait_cyc(8);
        settle();
        chk("dis_timeout_clr", 0, int'(act_to[0]), 0);
        chk("dis_no_strobe", 1, mvcnt[1] - s1, 0);
        chk("dis_held_high", 1, int'(act_h[1]), 150);
        seg(0, 4); seg(1, 4); seg(0, 4); seg(1, 4);
        settle();
        chk("rearm_strobes", 0, mvcnt[0] - s0, 1);
        chk("rearm_high", 1, int'(act_h[1]), 4);

        // enable dropped exactly on the completing rise
        seg(0, 5);
        s0 = mvcnt[0];
        seg_start(1, 6);
        wait_cyc(2);
        drop_enable(1);
        wait_cyc(6);
        settle();
        chk("rise_dis_strobe", 0, mvcnt[0] - s0, 0);
        seg(0, 3); seg(1, 5); seg(0, 3); seg(1, 5);
        settle();
        chk("rise_dis_high", 0, int'(act_h[0]), 5);
        chk("rise_dis_low", 0, int'(act_l[0]), 3);

        // Asynchronous reset in the middle of a low phase
        seg_start(0, 10);
        wait_cyc(4);
        #2 rst = 1'b1;
        cancel_from(cyc + 1);
        for (int i = 0; i < 2; i++) mstate[i] = 0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("arst_high", i, int'(act_h[i]), 0);
            chk("arst_low", i, int'(act_l[i]), 0);
            chk("arst_period", i, int'(act_p[i]), 0);
            chk("arst_valid", i, int'(act_mv[i]), 0);
        end
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(3);
        settle();
        s0 = mvcnt[0];
        seg(1, 3); seg(0, 5);
        settle();
        chk("arst_first_rise", 0, mvcnt[0] - s0, 0);
        seg(1, 3);
        settle();
        chk("arst_second_rise", 0, mvcnt[0] - s0, 1);
        chk("arst_meas_high", 0, int'(act_h[0]), 3);

        // 1-cycle pulses every 2 cycles
        seg(0, 3);
        s0 = mvcnt[0];
        repeat (6) begin
            seg(1, 1);
            seg(0, 1);
        end
        seg(1, 1);
        wait_cyc(3);
        settle();
        chk("fast_strobes", 0, mvcnt[0] - s0, 7);
        chk("fast_high", 0, int'(act_h[0]), 1);
        chk("fast_low", 1, int'(act_l[1]), 1);
        chk("fast_period", 0, int'(act_p[0]), 2);

        wait_cyc(5);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
